major_state_seq: RTL and testbench

- Major/minor state sequencer for the PDP-8/e core. Generates the 4-bit `state` bus (F0–F3, D0–D3, E0–E3, H0) that every datapath unit keys on, including the OPR group-2 skip evaluator, the AC/L logic and the memory interface.
- Decodes opcode and indirect bit from the instruction bus to choose Fetch→Defer→Execute paths.
- Handles front-panel HALT/CONT, single-instruction operation, memory wait stalls and interrupt acknowledge at instruction boundaries.

---
 rtl/major_state_seq_pkg.sv | 54 +++++
 rtl/major_state_seq_switch.sv | 38 +++
 rtl/major_state_seq.sv | 135 +++++++++++++
 tb/tb_major_state_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/major_state_seq_pkg.sv
// Shared definitions for the PDP-8/e major/minor state sequencer.
// State codes: F0..F3 = 0..3, D0..D3 = 4..7, E0..E3 = 8..11, H0 = 12.
// Codes 13..15 are unused and recover to H0.
// Opcode constants AND..OPR = 0..7 (instruction bits 0..2).
package major_state_seq_pkg;

    typedef enum logic [3:0] {
        ST_F0 = 4'd0,
        ST_F1 = 4'd1,
        ST_F2 = 4'd2,
        ST_F3 = 4'd3,
        ST_D0 = 4'd4,
        ST_D1 = 4'd5,
        ST_D2 = 4'd6,
        ST_D3 = 4'd7,
        ST_E0 = 4'd8,
        ST_E1 = 4'd9,
        ST_E2 = 4'd10,
        ST_E3 = 4'd11,
        ST_H0 = 4'd12
    } state_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_IOT = 3'd6;
    localparam logic [2:0] OP_OPR = 3'd7;

    // True when the given X3 state is the last minor state of the instruction.
    function automatic logic ends_at(input state_e st, input logic [2:0] op, input logic ind);
        logic res;
        case (st)
            ST_F3:   res = (op == OP_IOT) || (op == OP_OPR) || ((op == OP_JMP) && !ind);
            ST_D3:   res = (op == OP_JMP);
            ST_E3:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // OPR group 2 (bits 0..3 = 1111, bit 11 = 0) with the evaluator's skip asserted.
    function automatic logic group2_skip(input logic [3:0] top4, input logic bit11, input logic skip);
        return (top4 == 4'b1111) && !bit11 && skip;
    endfunction

    // Codes above H0 are not part of the sequence.
    function automatic logic state_legal(input state_e st);
        return (st <= ST_H0);
    endfunction

endpackage

// File: rtl/major_state_seq_switch.sv
// Front-panel switch synchroniser with registered rising-edge detector.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset, clears all flops
//   async_in   asynchronous switch level
//   sync_level synchronised level (last synchroniser stage)
//   sync_rise  one-cycle pulse after a 0->1 transition of sync_level
module switch_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_level,
    output logic sync_rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   rise_r;

    // Synchroniser chain plus edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
            rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign sync_level = sync_r[SYNC_STAGES-1];
    assign sync_rise  = rise_r;

endmodule

// File: rtl/major_state_seq.sv
// PDP-8/e major/minor state sequencer.
// Ports:
//   clk100      system clock
//   reset_n     asynchronous active-low reset
//   instruction current instruction, bit 0 = MSB (op = [0:2], indirect = [3])
//   skip        registered OPR group-2 skip, valid from F2
//   mem_wait    memory not ready, stalls F1/D1/E1
//   sw_halt     HALT/SING-INST switch (asynchronous level)
//   sw_cont     CONT switch (asynchronous level, rising edge acts)
//   int_req     OR of device interrupt requests
//   int_enable  ION (delay already applied)
//   state       current minor state code
//   run         RUN lamp
//   int_ack     pulse in the F0 that fetches the substituted JMS 0
//   pc_skip     pulse in F3 for a taken group-2 skip
//   instr_done  pulse in the last minor state of each instruction
module major_state_seq
    import major_state_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk100,
    input  logic        reset_n,
    input  logic [0:11] instruction,
    input  logic        skip,
    input  logic        mem_wait,
    input  logic        sw_halt,
    input  logic        sw_cont,
    input  logic        int_req,
    input  logic        int_enable,
    output logic [3:0]  state,
    output logic        run,
    output logic        int_ack,
    output logic        pc_skip,
    output logic        instr_done
);

    state_e     state_r;
    state_e     seq_next_s;
    state_e     next_state_s;
    logic       run_r;
    logic       int_ack_r;
    logic       pc_skip_r;
    logic       instr_done_r;
    logic       halt_s;
    logic       cont_rise_s;
    logic       end_s;
    logic [2:0] op_s;
    logic       ind_s;
    logic       unused_halt_rise_s;
    logic       unused_cont_level_s;
    logic       unused_instr_s;

    assign op_s           = instruction[0:2];
    assign ind_s          = instruction[3];
    assign unused_instr_s = ^instruction[4:10];

    switch_sync #(.SYNC_STAGES(SYNC_STAGES)) u_halt_sync (
        .clk        (clk100),
        .rst_n      (reset_n),
        .async_in   (sw_halt),
        .sync_level (halt_s),
        .sync_rise  (unused_halt_rise_s)
    );

    switch_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cont_sync (
        .clk        (clk100),
        .rst_n      (reset_n),
        .async_in   (sw_cont),
        .sync_level (unused_cont_level_s),
        .sync_rise  (cont_rise_s)
    );

    // Next minor state; END (last X3 of the instruction) overrides the walk.
    always_comb begin
        seq_next_s   = state_r;
        next_state_s = state_r;
        end_s        = ends_at(state_r, op_s, ind_s);
        case (state_r)
            ST_F0: seq_next_s = ST_F1;
            ST_F1: seq_next_s = mem_wait ? ST_F1 : ST_F2;
            ST_F2: seq_next_s = ST_F3;
            ST_F3: seq_next_s = ind_s ? ST_D0 : ST_E0;
            ST_D0: seq_next_s = ST_D1;
            ST_D1: seq_next_s = mem_wait ? ST_D1 : ST_D2;
            ST_D2: seq_next_s = ST_D3;
            ST_D3: seq_next_s = ST_E0;
            ST_E0: seq_next_s = ST_E1;
            ST_E1: seq_next_s = mem_wait ? ST_E1 : ST_E2;
            ST_E2: seq_next_s = ST_E3;
            ST_E3: seq_next_s = ST_F0;
            ST_H0: seq_next_s = cont_rise_s ? ST_F0 : ST_H0;
            default: seq_next_s = ST_H0;
        endcase
        if (end_s) begin
            next_state_s = halt_s ? ST_H0 : ST_F0;
        end else begin
            next_state_s = seq_next_s;
        end
    end

    // State register and registered outputs; pulses are computed for the state being entered.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_H0;
            run_r        <= 1'b0;
            int_ack_r    <= 1'b0;
            pc_skip_r    <= 1'b0;
            instr_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            instr_done_r <= ends_at(next_state_s, op_s, ind_s);
            pc_skip_r    <= (next_state_s == ST_F3) &&
                            group2_skip(instruction[0:3], instruction[11], skip);
            // Halt has priority: a pending interrupt waits for a later boundary.
            int_ack_r    <= end_s && !halt_s && int_req && int_enable;
            if ((state_r == ST_H0) && cont_rise_s) begin
                run_r <= 1'b1;
            end else if (end_s && halt_s) begin
                run_r <= 1'b0;
            end else if (!state_legal(state_r)) begin
                run_r <= 1'b0;
            end else begin
                run_r <= run_r;
            end
        end
    end

    assign state      = state_r;
    assign run        = run_r;
    assign int_ack    = int_ack_r;
    assign pc_skip    = pc_skip_r;
    assign instr_done = instr_done_r;

endmodule

// File: tb/tb_major_state_seq.sv
// Randomised scoreboard bench for major_state_seq with a path-based reference model.
module tb_major_state_seq;
    import major_state_seq_pkg::*;

    localparam int SYNC = 2;

    logic        clk100 = 1'b0;
    logic        reset_n;
    logic [0:11] instruction;
    logic        skip, mem_wait, sw_halt, sw_cont, int_req, int_enable;
    logic [3:0]  state;
    logic        run, int_ack, pc_skip, instr_done;

    major_state_seq #(.SYNC_STAGES(SYNC)) dut (
        .clk100      (clk100),
        .reset_n     (reset_n),
        .instruction (instruction),
        .skip        (skip),
        .mem_wait    (mem_wait),
        .sw_halt     (sw_halt),
        .sw_cont     (sw_cont),
        .int_req     (int_req),
        .int_enable  (int_enable),
        .state       (state),
        .run         (run),
        .int_ack     (int_ack),
        .pc_skip     (pc_skip),
        .instr_done  (instr_done)
    );

    always #5 clk100 = ~clk100;

    typedef struct packed {
        logic [3:0] st;
        logic       run;
        logic       ack;
        logic       pcs;
        logic       done;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [0:11] prog[$];
    int          mon_checks = 0, mon_errors = 0;
    int          dir_checks = 0, dir_errors = 0;
    bit          chk_en = 1'b0;
    bit          rnd = 1'b0;

    // Reference model: position along the instruction's list of minor states.
    int m_state, m_pos;
    bit m_run, m_iack, m_pcs, m_done, m_new_f0;
    bit hh[$], hc[$];

    function automatic bit has_defer(input logic [0:11] ins);
        int op = int'(ins[0:2]);
        return (op < 6) && ins[3];
    endfunction

    function automatic int path_len(input logic [0:11] ins);
        int op = int'(ins[0:2]);
        int len = 4;
        if (op < 6) begin
            if (ins[3]) len += 4;
            if (op != 5) len += 4;
        end
        return len;
    endfunction

    function automatic int path_at(input logic [0:11] ins, input int pos);
        if (pos < 4) return pos;
        if (has_defer(ins) && pos < 8) return pos;
        return 8 + (pos % 4);
    endfunction

    function automatic void model_reset();
        m_state = 12; m_pos = 0; m_run = 0;
        m_iack = 0; m_pcs = 0; m_done = 0; m_new_f0 = 0;
        hh.delete(); hc.delete();
        for (int i = 0; i < SYNC + 2; i++) begin
            hh.push_back(1'b0);
            hc.push_back(1'b0);
        end
    endfunction

    // One clock edge of the reference model, using the inputs present at that edge.
    function automatic void model_edge();
        bit halt_e = hh[SYNC-1];
        bit rise   = hc[SYNC] && !hc[SYNC+1];
        int last   = path_len(instruction) - 1;
        m_iack = 0; m_pcs = 0; m_new_f0 = 0;
        if (m_state == 12) begin
            if (rise) begin
                m_state = 0; m_pos = 0; m_run = 1; m_new_f0 = 1;
            end
        end else if ((m_state % 4) == 1 && mem_wait) begin
            m_pos = m_pos;
        end else if (m_pos == last) begin
            if (halt_e) begin
                m_state = 12; m_run = 0;
            end else begin
                m_state = 0; m_pos = 0; m_new_f0 = 1;
                m_iack = int_req && int_enable;
            end
        end else begin
            m_pos++;
            m_state = path_at(instruction, m_pos);
            if (m_state == 3)
                m_pcs = (instruction[0:3] == 4'b1111) && !instruction[11] && skip;
        end
        m_done = (m_state != 12) && (m_pos == last);
        hh.push_front(sw_halt); void'(hh.pop_back());
        hc.push_front(sw_cont); void'(hc.pop_back());
    endfunction

    task automatic cyc();
        @(posedge clk100);
        model_edge();
        exp_q.push_back({4'(m_state), m_run, m_iack, m_pcs, m_done});
        #1;
        if (m_new_f0) begin
            if (m_iack) instruction = 12'o4000;
            else if (prog.size() > 0) instruction = prog.pop_front();
            else if (rnd) instruction = 12'($urandom_range(0, 4095));
        end
        if (rnd) begin
            mem_wait   = ($urandom_range(0, 3) == 0);
            skip       = 1'($urandom_range(0, 1));
            int_req    = ($urandom_range(0, 7) == 0);
            int_enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) sw_halt = !sw_halt;
            if ($urandom_range(0, 15) == 0) sw_cont = !sw_cont;
        end
    endtask

    task automatic cont_pulse();
        sw_cont = 1'b1;
        repeat (4) cyc();
        sw_cont = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        dir_checks++;
        if (got !== expv) begin
            dir_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Run until the model reaches a state with a given instruction, bounded.
    task automatic run_until(input int target, input logic [0:11] ins, input int budget, input string name);
        int n = 0;
        while (!(m_state == target && instruction == ins) && n < budget) begin
            cyc();
            n++;
        end
        chk(name, 32'(state), 32'(target));
    endtask

    // Monitor: every cycle the DUT presents a full output tuple.
    always @(negedge clk100) begin
        if (chk_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_checks++;
            if ({state, run, int_ack, pc_skip, instr_done} !== mon_e) begin
                mon_errors++;
                $display("FAIL seq t=%0t: got st=%0d run=%0b ack=%0b skip=%0b done=%0b expected st=%0d run=%0b ack=%0b skip=%0b done=%0b",
                         $time, state, run, int_ack, pc_skip, instr_done,
                         mon_e.st, mon_e.run, mon_e.ack, mon_e.pcs, mon_e.done);
            end
        end
    end

    initial begin
        int waits;
        reset_n = 1'b0; instruction = 12'o7000;
        skip = 0; mem_wait = 0; sw_halt = 0; sw_cont = 0; int_req = 0; int_enable = 0;
        repeat (3) @(posedge clk100);
        #1;
        chk("reset_state", 32'(state), 32'd12);
        chk("reset_run", 32'(run), 32'd0);
        chk("reset_pulses", 32'({int_ack, pc_skip, instr_done}), 32'd0);
        @(negedge clk100);
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // NOP loop after CONT
        cont_pulse();
        repeat (12) cyc();

        // TAD I with a 3-cycle memory stall in D1
        prog.push_back(12'o1400);
        waits = 0;
        repeat (40) begin
            cyc();
            if (m_state == 5 && waits < 3) begin
                mem_wait = 1'b1; waits++;
            end else begin
                mem_wait = 1'b0;
            end
        end

        // Group-2 skip taken (SMA) and suppressed (bit 11 set)
        skip = 1'b1;
        prog.push_back(12'o7500);
        repeat (20) cyc();
        prog.push_back(12'o7501);
        repeat (20) cyc();
        skip = 1'b0;

        // Halt during JMP direct, then single-instruction CONT
        prog.push_back(12'o5200);
        run_until(0, 12'o5200, 40, "reach_jmp");
        sw_halt = 1'b1;
        run_until(12, 12'o5200, 20, "halt_h0");
        chk("halt_run", 32'(run), 32'd0);
        cont_pulse();
        repeat (10) cyc();
        chk("single_inst_h0", 32'(state), 32'd12);
        sw_halt = 1'b0;
        cont_pulse();

        // Interrupt at the end of DCA
        prog.push_back(12'o3000);
        run_until(11, 12'o3000, 40, "reach_dca_e3");
        int_req = 1'b1; int_enable = 1'b1;
        cyc();
        int_req = 1'b0; int_enable = 1'b0;
        chk("int_ack_f0", 32'({state, int_ack}), 32'h01);
        repeat (14) cyc();

        // Randomised traffic
        rnd = 1'b1;
        repeat (3000) cyc();
        rnd = 1'b0;
        mem_wait = 0; skip = 0; int_req = 0; int_enable = 0; sw_halt = 0; sw_cont = 0;
        repeat (6) cyc();

        // Asynchronous reset in E2
        prog.delete();
        prog.push_back(12'o3000);
        cont_pulse();
        run_until(10, 12'o3000, 80, "reach_e2");
        @(negedge clk100);
        #2;
        reset_n = 1'b0;
        chk_en  = 1'b0;
        #1;
        exp_q.delete();
        chk("async_reset_state", 32'(state), 32'd12);
        chk("async_reset_outs", 32'({run, int_ack, pc_skip, instr_done}), 32'd0);

        // Illegal state code recovers to H0
        repeat (2) @(posedge clk100);
        @(negedge clk100);
        reset_n = 1'b1;
        @(negedge clk100);
        force dut.state_r = state_e'(4'd14);
        #1;
        release dut.state_r;
        @(posedge clk100);
        #1;
        chk("illegal_recover", 32'(state), 32'd12);
        chk("illegal_run", 32'(run), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 mon_checks + dir_checks, mon_errors + dir_errors);
        $finish;
    end

endmodule
